// File: rtl/colmix_1942.sv
// Final colour mixer: fixed-priority layer select, three writable palette PROMs
// and a 3-tick pixel pipeline that keeps blanking aligned with colour.
module colmix_1942 #(
  parameter int VULGUS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen6,
  input  logic       preLHBL,
  input  logic       preLVBL,
  input  logic [3:0] char_pxl,
  input  logic [5:0] scr_pxl,
  input  logic [3:0] obj_pxl,
  input  logic [7:0] prog_addr,
  input  logic [3:0] prom_din,
  input  logic       prom_e8_we,
  input  logic       prom_e9_we,
  input  logic       prom_e10_we,
  input  logic [3:0] gfx_en,
  output logic       LHBL,
  output logic       LVBL,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam logic [1:0] CHAR_PFX = (VULGUS != 0) ? 2'b11 : 2'b10;
  localparam logic [1:0] OBJ_PFX  = (VULGUS != 0) ? 2'b10 : 2'b01;

  logic [3:0] r_pal_r [0:255];
  logic [3:0] r_pal_g [0:255];
  logic [3:0] r_pal_b [0:255];

  logic       w_char_on;
  logic       w_obj_on;
  logic [5:0] w_scr_code;
  logic [7:0] w_addr;
  logic       w_unused_en;

  logic [7:0] r_addr_p0;
  logic       r_hb_p0, r_hb_p1, r_hb_p2;
  logic       r_vb_p0, r_vb_p1, r_vb_p2;
  logic [3:0] r_red_p1, r_green_p1, r_blue_p1;
  logic [3:0] r_red_p2, r_green_p2, r_blue_p2;

  assign w_unused_en = gfx_en[3];
  assign w_char_on   = gfx_en[0] && (char_pxl != 4'hF);
  assign w_obj_on    = gfx_en[2] && (obj_pxl != 4'hF);
  // A disabled scroll layer still wins when nothing is above it, showing entry 0.
  assign w_scr_code  = gfx_en[1] ? scr_pxl : 6'h00;

  always_comb begin
    w_addr = {2'b00, w_scr_code};
    if (w_char_on) begin
      w_addr = {CHAR_PFX, 2'b00, char_pxl};
    end else if (w_obj_on) begin
      w_addr = {OBJ_PFX, 2'b00, obj_pxl};
    end
  end

  // Palette writes are independent of cen6; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (prom_e8_we)  r_pal_r[prog_addr] <= prom_din;
    if (prom_e9_we)  r_pal_g[prog_addr] <= prom_din;
    if (prom_e10_we) r_pal_b[prog_addr] <= prom_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_p0  <= 8'h00;
      r_hb_p0    <= 1'b0;
      r_hb_p1    <= 1'b0;
      r_hb_p2    <= 1'b0;
      r_vb_p0    <= 1'b0;
      r_vb_p1    <= 1'b0;
      r_vb_p2    <= 1'b0;
      r_red_p1   <= 4'h0;
      r_green_p1 <= 4'h0;
      r_blue_p1  <= 4'h0;
      r_red_p2   <= 4'h0;
      r_green_p2 <= 4'h0;
      r_blue_p2  <= 4'h0;
    end else if (cen6) begin
      // stage 1: palette address and blanking capture
      r_addr_p0 <= w_addr;
      r_hb_p0   <= preLHBL;
      r_vb_p0   <= preLVBL;
      // stage 2: palette read
      r_red_p1   <= r_pal_r[r_addr_p0];
      r_green_p1 <= r_pal_g[r_addr_p0];
      r_blue_p1  <= r_pal_b[r_addr_p0];
      r_hb_p1    <= r_hb_p0;
      r_vb_p1    <= r_vb_p0;
      // stage 3: output register, blanked with the blank that emerges alongside it
      r_hb_p2 <= r_hb_p1;
      r_vb_p2 <= r_vb_p1;
      if (!r_hb_p1 || !r_vb_p1) begin
        r_red_p2   <= 4'h0;
        r_green_p2 <= 4'h0;
        r_blue_p2  <= 4'h0;
      end else begin
        r_red_p2   <= r_red_p1;
        r_green_p2 <= r_green_p1;
        r_blue_p2  <= r_blue_p1;
      end
    end
  end

  assign LHBL  = r_hb_p2;
  assign LVBL  = r_vb_p2;
  assign red   = r_red_p2;
  assign green = r_green_p2;
  assign blue  = r_blue_p2;

endmodule

// File: tb/tb_colmix_1942.sv
// Bench for colmix_1942: both palette layouts against a delay-line model of the
// mixer, plus hand-computed expectations for the key pixel cases.
module tb_colmix_1942;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen6 = 1'b0;
  logic       preLHBL = 1'b0;
  logic       preLVBL = 1'b0;
  logic [3:0] char_pxl = 4'hF;
  logic [5:0] scr_pxl = 6'h00;
  logic [3:0] obj_pxl = 4'hF;
  logic [7:0] prog_addr = 8'h00;
  logic [3:0] prom_din = 4'h0;
  logic       e8 = 1'b0, e9 = 1'b0, e10 = 1'b0;
  logic [3:0] gfx_en = 4'h0;

  logic       lh0, lv0, lh1, lv1;
  logic [3:0] r0, g0, b0, r1, g1, b1;

  int  checks = 0;
  int  errors = 0;
  bit  chk_on = 1'b0;

  always #5 clk = ~clk;

  colmix_1942 #(.VULGUS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cen6(cen6), .preLHBL(preLHBL), .preLVBL(preLVBL),
    .char_pxl(char_pxl), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl),
    .prog_addr(prog_addr), .prom_din(prom_din),
    .prom_e8_we(e8), .prom_e9_we(e9), .prom_e10_we(e10), .gfx_en(gfx_en),
    .LHBL(lh0), .LVBL(lv0), .red(r0), .green(g0), .blue(b0));

  colmix_1942 #(.VULGUS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cen6(cen6), .preLHBL(preLHBL), .preLVBL(preLVBL),
    .char_pxl(char_pxl), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl),
    .prog_addr(prog_addr), .prom_din(prom_din),
    .prom_e8_we(e8), .prom_e9_we(e9), .prom_e10_we(e10), .gfx_en(gfx_en),
    .LHBL(lh1), .LVBL(lv1), .red(r1), .green(g1), .blue(b1));

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] paddr(input bit vul, input logic [3:0] c,
                                       input logic [3:0] o, input logic [5:0] s,
                                       input logic [3:0] en);
    if (en[0] && c != 4'hF) return {(vul ? 2'b11 : 2'b10), 2'b00, c};
    if (en[2] && o != 4'hF) return {(vul ? 2'b10 : 2'b01), 2'b00, o};
    return en[1] ? {2'b00, s} : 8'h00;
  endfunction

  // Reference model: each pixel tick pushes a record into a 3-deep delay line.
  // The record picks up its colours one tick after sampling (from the palette as
  // it was before that edge's write) and is shown when it reaches the end.
  typedef struct packed {
    logic                  hb;
    logic                  vb;
    logic [1:0][7:0]       a;
    logic [1:0][2:0][3:0]  c;
  } ent_t;

  logic [3:0] pal [3][256];
  ent_t       h [3];
  logic       exp_hb, exp_vb;
  logic [3:0] exp_c [2][3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) h[i] = '0;
      exp_hb = 1'b0;
      exp_vb = 1'b0;
      for (int v = 0; v < 2; v++)
        for (int k = 0; k < 3; k++) exp_c[v][k] = 4'h0;
    end else begin
      if (cen6) begin
        h[2] = h[1];
        h[1] = h[0];
        h[0] = '0;
        h[0].hb = preLHBL;
        h[0].vb = preLVBL;
        h[0].a[0] = paddr(1'b0, char_pxl, obj_pxl, scr_pxl, gfx_en);
        h[0].a[1] = paddr(1'b1, char_pxl, obj_pxl, scr_pxl, gfx_en);
        for (int v = 0; v < 2; v++)
          for (int k = 0; k < 3; k++) h[1].c[v][k] = pal[k][h[1].a[v]];
        exp_hb = h[2].hb;
        exp_vb = h[2].vb;
        for (int v = 0; v < 2; v++)
          for (int k = 0; k < 3; k++)
            exp_c[v][k] = (h[2].hb && h[2].vb) ? h[2].c[v][k] : 4'h0;
      end
      if (e8)  pal[0][prog_addr] = prom_din;
      if (e9)  pal[1][prog_addr] = prom_din;
      if (e10) pal[2][prog_addr] = prom_din;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_LHBL0", {7'd0, lh0}, {7'd0, exp_hb});
      check("m_LVBL0", {7'd0, lv0}, {7'd0, exp_vb});
      check("m_LHBL1", {7'd0, lh1}, {7'd0, exp_hb});
      check("m_LVBL1", {7'd0, lv1}, {7'd0, exp_vb});
      check("m_red0",   {4'd0, r0}, {4'd0, exp_c[0][0]});
      check("m_green0", {4'd0, g0}, {4'd0, exp_c[0][1]});
      check("m_blue0",  {4'd0, b0}, {4'd0, exp_c[0][2]});
      check("m_red1",   {4'd0, r1}, {4'd0, exp_c[1][0]});
      check("m_green1", {4'd0, g1}, {4'd0, exp_c[1][1]});
      check("m_blue1",  {4'd0, b1}, {4'd0, exp_c[1][2]});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      cen6 = 1'b1;
      @(negedge clk);
      cen6 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic set_pix(input logic [3:0] c, input logic [3:0] o,
                         input logic [5:0] s, input logic [3:0] en);
    char_pxl = c;
    obj_pxl  = o;
    scr_pxl  = s;
    gfx_en   = en;
  endtask

  task automatic lit_rgb(input string nm, input logic [3:0] rr, input logic [3:0] gg,
                         input logic [3:0] bb, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc);
    check({nm, "_r0"}, {4'd0, r0}, {4'd0, rr});
    check({nm, "_g0"}, {4'd0, g0}, {4'd0, gg});
    check({nm, "_b0"}, {4'd0, b0}, {4'd0, bb});
    check({nm, "_r1"}, {4'd0, r1}, {4'd0, ra});
    check({nm, "_g1"}, {4'd0, g1}, {4'd0, rb});
    check({nm, "_b1"}, {4'd0, b1}, {4'd0, rc});
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++) pal[k][a] = 4'h0;

    repeat (3) @(negedge clk);
    check("rst_LHBL", {7'd0, lh0}, 8'h00);
    check("rst_red", {4'd0, r0}, 8'h00);
    rst_n = 1'b1;

    // Palette: R = addr[3:0], G = addr[7:4], B = addr[3:0] ^ addr[7:4]
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 256; a++) begin
        logic [7:0] av;
        av = 8'(a);
        prog_addr = av;
        prom_din  = (k == 0) ? av[3:0] : (k == 1) ? av[7:4] : (av[3:0] ^ av[7:4]);
        e8  = (k == 0);
        e9  = (k == 1);
        e10 = (k == 2);
        @(negedge clk);
      end
    end
    e8 = 1'b0; e9 = 1'b0; e10 = 1'b0;
    chk_on = 1'b1;

    preLHBL = 1'b1;
    preLVBL = 1'b1;
    set_pix(4'h3, 4'h5, 6'h07, 4'h7);
    tick(2);
    check("startup_red", {4'd0, r0}, 8'h00);
    check("startup_LHBL", {7'd0, lh0}, 8'h00);
    tick(1);
    check("startup_LHBL_up", {7'd0, lh0}, 8'h01);
    lit_rgb("char", 4'h3, 4'h8, 4'hB, 4'h3, 4'hC, 4'hF);

    set_pix(4'hF, 4'h5, 6'h07, 4'h7);
    tick(3);
    lit_rgb("obj", 4'h5, 4'h4, 4'h1, 4'h5, 4'h8, 4'hD);

    set_pix(4'hF, 4'hF, 6'h07, 4'h7);
    tick(3);
    lit_rgb("scr", 4'h7, 4'h0, 4'h7, 4'h7, 4'h0, 4'h7);

    set_pix(4'h3, 4'h5, 6'h07, 4'h6);
    tick(3);
    lit_rgb("char_off", 4'h5, 4'h4, 4'h1, 4'h5, 4'h8, 4'hD);

    set_pix(4'h3, 4'h5, 6'h2A, 4'h0);
    tick(3);
    lit_rgb("all_off", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("all_off_LHBL", {7'd0, lh0}, 8'h01);

    set_pix(4'hF, 4'hF, 6'h2A, 4'h7);
    tick(3);
    lit_rgb("scr2a", 4'hA, 4'h2, 4'h8, 4'hA, 4'h2, 4'h8);

    set_pix(4'hF, 4'hF, 6'h07, 4'h7);
    tick(3);
    preLHBL = 1'b0;
    tick(1);
    preLHBL = 1'b1;
    tick(1);
    check("blank_pre_LHBL", {7'd0, lh0}, 8'h01);
    check("blank_pre_red", {4'd0, r0}, 8'h07);
    tick(1);
    check("blank_LHBL", {7'd0, lh0}, 8'h00);
    check("blank_LVBL", {7'd0, lv0}, 8'h01);
    lit_rgb("blank", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    check("blank_post_LHBL", {7'd0, lh0}, 8'h01);
    check("blank_post_red", {4'd0, r0}, 8'h07);

    for (int i = 0; i < 10; i++) begin
      set_pix(4'($urandom), 4'($urandom), 6'($urandom), 4'($urandom));
      preLHBL = 1'($urandom);
      preLVBL = 1'($urandom);
      @(negedge clk);
    end
    check("frozen_red", {4'd0, r0}, 8'h07);
    check("frozen_LHBL", {7'd0, lh0}, 8'h01);
    preLHBL = 1'b1;
    preLVBL = 1'b1;

    prog_addr = 8'h45;
    prom_din  = 4'hA;
    e9 = 1'b1;
    @(negedge clk);
    e9 = 1'b0;
    set_pix(4'hF, 4'h5, 6'h07, 4'h7);
    tick(3);
    lit_rgb("write", 4'h5, 4'hA, 4'h1, 4'h5, 4'h8, 4'hD);

    for (int i = 0; i < 800; i++) begin
      set_pix(4'($urandom), 4'($urandom), 6'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) char_pxl = 4'hF;
      if ($urandom_range(0, 3) == 0) obj_pxl = 4'hF;
      preLHBL   = ($urandom_range(0, 7) != 0);
      preLVBL   = ($urandom_range(0, 7) != 0);
      cen6      = ($urandom_range(0, 2) == 0);
      prog_addr = 8'($urandom);
      prom_din  = 4'($urandom);
      e8  = ($urandom_range(0, 15) == 0);
      e9  = ($urandom_range(0, 15) == 0);
      e10 = ($urandom_range(0, 15) == 0);
      if (i == 400) begin
        e8 = 1'b0; e9 = 1'b0; e10 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_LHBL", {7'd0, lh0}, 8'h00);
        check("async_rst_LVBL", {7'd0, lv1}, 8'h00);
        check("async_rst_red", {4'd0, r0}, 8'h00);
        check("async_rst_blue", {4'd0, b1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    cen6 = 1'b0;
    e8 = 1'b0; e9 = 1'b0; e10 = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/colmix_1942.md
Name: colmix_1942

Overview:
- Final colour mixer for the 1942/Vulgus video path.
- Takes per-pixel colour codes from the char, scroll and object generators and chooses the visible layer by fixed priority.
- Looks up 4-bit R/G/B through three writable 256x4 palette PROMs and aligns the blanking signals with the colour pipeline.
- Sits after the layer generators and drives the RGB/blanking outputs of the video block.

Parameters:
- VULGUS, 0: palette address layout select. 0 = 1942 layout, 1 = Vulgus layout (see Behaviour).

Ports:
- clk  input  1  system clock; the single clock of the block.
- rst_n  input  1  asynchronous active-low reset.
- cen6  input  1  pixel clock enable, one clk pulse per pixel.
- preLHBL  input  1  horizontal blank from the timer, active low, not delayed.
- preLVBL  input  1  vertical blank from the timer, active low, not delayed.
- char_pxl  input  4  char colour code; 4'hF = transparent.
- scr_pxl  input  6  scroll colour code; always opaque.
- obj_pxl  input  4  object colour code; 4'hF = transparent.
- prog_addr  input  8  PROM write address.
- prom_din  input  4  PROM write data.
- prom_e8_we  input  1  write strobe, red PROM.
- prom_e9_we  input  1  write strobe, green PROM.
- prom_e10_we  input  1  write strobe, blue PROM.
- gfx_en  input  4  layer enables: bit0 char, bit1 scroll, bit2 obj; bit3 unused.
- LHBL  output  1  delayed horizontal blank, active low.
- LVBL  output  1  delayed vertical blank, active low.
- red  output  4  red output.
- green  output  4  green output.
- blue  output  4  blue output.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pipeline registers, red/green/blue, LHBL and LVBL go to 0;
  - PROM contents are not cleared.
- Layer enables: a layer whose gfx_en bit is 0 is treated as transparent. A disabled scroll layer contributes code 6'h00 with prefix forced, so it is still selectable.
- Priority: char if enabled and char_pxl != 4'hF; else obj if enabled and obj_pxl != 4'hF; else scroll.
- Palette address, VULGUS=0:
  - char → {2'b10, 2'b00, char_pxl}
  - obj → {2'b01, 2'b00, obj_pxl}
  - scroll → {2'b00, scr_pxl}
- Palette address, VULGUS=1:
  - char → {2'b11, 2'b00, char_pxl}
  - obj → {2'b10, 2'b00, obj_pxl}
  - scroll → {2'b00, scr_pxl}
- Pipeline: every stage advances only on clk edges with cen6=1; nothing changes when cen6=0.
  - Stage 1: register the selected palette address.
  - Stage 2: synchronous read of the R, G and B PROMs at that address.
  - Stage 3: output register.
  - Total latency is 3 cen6 ticks from input sample to red/green/blue.
- Blanking:
  - preLHBL and preLVBL pass through a 3-tick cen6 shift register to produce LHBL and LVBL.
  - The stage-3 register loads 0 on all colours when either 2-tick-delayed blank is low, so zero colour coincides exactly with LHBL/LVBL low.
- PROM write:
  - on any clk edge with a we high, the selected PROM word at prog_addr takes prom_din; cen6 is not required;
  - several we signals high at once write each selected PROM;
  - a read of the same address in the same cycle returns the old data.
- PROM reads continue during writes; there is no lockout.

Test Plan:
- Reset: assert rst_n=0 mid-frame → red/green/blue=0 and LHBL=LVBL=0 immediately. Deassert → colours stay 0 until valid pixels reach stage 3.
- Priority: load R PROM with addr→addr[3:0] and preset G/B similarly. Set char=4'h3, obj=4'h5, scr=6'h07, gfx_en=4'h7, blanks high → after 3 cen6 ticks red=3 (address 8'h83). Set char=4'hF → red=5 (8'h45). Set obj=4'hF → red=7 (8'h07).
- Layer disable: char=4'h3 with gfx_en=4'h6 → object colour is output. With gfx_en=4'h0 → scroll address 8'h00 is output.
- Blank alignment: drop preLHBL for 1 tick → LHBL is low exactly 3 ticks later for 1 tick, and colours are 0 in that same tick only.
- cen6 gating: hold cen6=0 for 10 clk while inputs change → outputs are frozen.
- PROM write: write 4'hA to E9 at 8'h45 while E8/E10 we are low → only green changes to A for obj pixel 5. With VULGUS=1 the same obj pixel reads address 8'h85.
